// File: rtl/mm_bus_master.sv
// Single-outstanding memory-mapped bus master: one CPU load/store at a time,
// ack or timeout abort. Optional error capture enabled by `define MM_ERR_CAPTURE_EN.
module mm_bus_master #(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic        cpu_ready_o,
   output logic        cpu_done_o,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_err_o,
   output logic        bus_write_o,
   output logic        bus_read_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   input  logic [31:0] bus_rdata_i,
`ifdef MM_ERR_CAPTURE_EN
   input  logic        err_clr_i,
   output logic        err_valid_o,
   output logic [31:0] err_addr_o,
`endif
   input  logic        bus_ack_i
);

   localparam int         CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t         state_r, state_s;
   logic [CW-1:0]  cnt_r, cnt_s;
   logic           we_r, we_s;
   logic           accept_s;
   logic           timeout_s;
   logic [31:0]    rdata_s;
   logic           err_s;

   assign accept_s = (state_r == ST_IDLE) && cpu_req_i;

   // Next-state, timeout counter and response capture
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      rdata_s   = cpu_rdata_o;
      err_s     = cpu_err_o;
      timeout_s = 1'b0;
      we_s      = accept_s ? cpu_we_i : we_r;
      case (state_r)
         ST_IDLE: begin
            if (cpu_req_i) begin
               state_s = ST_ACCESS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // ack checked first so an ack on the final cycle beats the timeout
            if (bus_ack_i) begin
               rdata_s = we_r ? 32'h0000_0000 : bus_rdata_i;
               err_s   = 1'b0;
               state_s = ST_RESP;
            end else if (cnt_r == CNT_LAST) begin
               rdata_s   = ERR_DATA;
               err_s     = 1'b1;
               timeout_s = 1'b1;
               state_s   = ST_RESP;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_RESP: begin
            cnt_s   = '0;
            state_s = ST_IDLE;
         end
         default: begin
            cnt_s   = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered CPU/bus outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         we_r        <= 1'b0;
         cpu_ready_o <= 1'b1;
         cpu_done_o  <= 1'b0;
         cpu_rdata_o <= 32'h0000_0000;
         cpu_err_o   <= 1'b0;
         bus_write_o <= 1'b0;
         bus_read_o  <= 1'b0;
         bus_addr_o  <= 32'h0000_0000;
         bus_data_o  <= 32'h0000_0000;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         we_r        <= we_s;
         cpu_ready_o <= (state_s == ST_IDLE);
         cpu_done_o  <= (state_s == ST_RESP);
         cpu_rdata_o <= rdata_s;
         cpu_err_o   <= err_s;
         bus_write_o <= (state_s == ST_ACCESS) && we_s;
         bus_read_o  <= (state_s == ST_ACCESS) && !we_s;
         if (accept_s) begin
            bus_addr_o <= cpu_addr_i;
            bus_data_o <= cpu_wdata_i;
         end else begin
            bus_addr_o <= bus_addr_o;
            bus_data_o <= bus_data_o;
         end
      end
   end

`ifdef MM_ERR_CAPTURE_EN
   // Sticky first-timeout capture; a new timeout outranks a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= 32'h0000_0000;
      end else if (timeout_s) begin
         err_valid_o <= 1'b1;
         if (!err_valid_o) begin
            err_addr_o <= bus_addr_o;
         end else begin
            err_addr_o <= err_addr_o;
         end
      end else if (err_clr_i) begin
         err_valid_o <= 1'b0;
         err_addr_o  <= err_addr_o;
      end else begin
         err_valid_o <= err_valid_o;
         err_addr_o  <= err_addr_o;
      end
   end
`else
   logic unused_s;
   assign unused_s = timeout_s;
`endif

endmodule

// File: tb/tb_mm_bus_master.sv
// Randomized self-checking bench for mm_bus_master; the bench plays the slave
// and predicts each transaction's strobe length, response data and error flag.
module tb_mm_bus_master;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_ready, cpu_done, cpu_err;
   logic [31:0] cpu_rdata;
   logic        bus_write, bus_read;
   logic [31:0] bus_addr, bus_data, bus_rdata;
   logic        bus_ack;
`ifdef MM_ERR_CAPTURE_EN
   logic        err_clr;
   logic        err_valid;
   logic [31:0] err_addr;
   logic        valid_m;
   logic [31:0] addr_m;
`endif

   int          n_vec  = 0;
   int          n_miss = 0;
   logic [31:0] mem [16];

   mm_bus_master #(.TIMEOUT_CYCLES(TO), .ERR_DATA(32'hDEADBEEF)) dut (
      .clk(clk), .rst(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_ready_o(cpu_ready), .cpu_done_o(cpu_done), .cpu_rdata_o(cpu_rdata), .cpu_err_o(cpu_err),
      .bus_write_o(bus_write), .bus_read_o(bus_read), .bus_addr_o(bus_addr), .bus_data_o(bus_data),
      .bus_rdata_i(bus_rdata),
`ifdef MM_ERR_CAPTURE_EN
      .err_clr_i(err_clr), .err_valid_o(err_valid), .err_addr_o(err_addr),
`endif
      .bus_ack_i(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One transaction; ack_at is the ACCESS cycle index the slave acks on, <0 = never
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int ack_at);
      int          n_strobe;
      logic        exp_err;
      logic [31:0] exp_rdata;
      exp_err   = !(ack_at >= 0 && ack_at < TO);
      n_strobe  = exp_err ? TO : ack_at + 1;
      exp_rdata = exp_err ? 32'hDEADBEEF : (we ? 32'h0 : mem[addr[5:2]]);
      @(negedge clk);
      check("ready_idle", 32'(cpu_ready), 32'd1);
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      @(negedge clk);
      for (int k = 0; k < n_strobe; k++) begin
         cpu_req = 1'($urandom_range(0, 1)); cpu_we = ~we;
         cpu_addr = $urandom; cpu_wdata = $urandom;
         check("strobe", {30'd0, bus_write, bus_read}, we ? 32'd2 : 32'd1);
         check("bus_addr", bus_addr, addr);
         if (we) check("bus_data", bus_data, wdata);
         check("busy_flags", {30'd0, cpu_ready, cpu_done}, 32'd0);
         bus_ack   = (k == ack_at);
         bus_rdata = bus_ack ? mem[addr[5:2]] : $urandom;
         @(negedge clk);
      end
      bus_ack = 1'b0;
      cpu_req = 1'($urandom_range(0, 1));
      check("done", {30'd0, cpu_done, cpu_ready}, 32'd2);
      check("strobe_resp", {30'd0, bus_write, bus_read}, 32'd0);
      check("err", 32'(cpu_err), 32'(exp_err));
      check("rdata", cpu_rdata, exp_rdata);
      if (we && !exp_err) mem[addr[5:2]] = wdata;
`ifdef MM_ERR_CAPTURE_EN
      if (exp_err && !valid_m) begin
         valid_m = 1'b1; addr_m = addr;
      end
      check("err_valid", 32'(err_valid), 32'(valid_m));
      if (valid_m) check("err_addr", err_addr, addr_m);
`endif
      @(negedge clk);
      cpu_req = 1'b0;
      check("post_done", {30'd0, cpu_done, cpu_ready}, 32'd1);
   endtask

   initial begin
      int ack_at, nstb, ndone, nrdy, nboth;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
      bus_ack = 1'b0; bus_rdata = 32'h0;
      rst = 1'b0;
`ifdef MM_ERR_CAPTURE_EN
      err_clr = 1'b0; valid_m = 1'b0; addr_m = 32'h0;
`endif
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(cpu_ready), 32'd1);
      check("rst_flags", {28'd0, cpu_done, cpu_err, bus_write, bus_read}, 32'd0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_baddr", bus_addr, 32'h0);
      check("rst_bdata", bus_data, 32'h0);
      rst = 1'b0;

      run_txn(1'b1, 32'h4000_0000, 32'h0000_03FF, 0);
      mem[0] = 32'hFFFF_FD55;
      run_txn(1'b0, 32'h4000_0000, 32'h0, 0);
      run_txn(1'b0, 32'h5000_0000, 32'h0, -1);
      run_txn(1'b0, 32'h4000_0004, 32'h0, TO - 1);
      run_txn(1'b1, 32'h4000_0008, 32'h1234_5678, TO - 1);
      run_txn(1'b1, 32'h5000_0010, 32'hCAFE_F00D, -1);

`ifdef MM_ERR_CAPTURE_EN
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0; valid_m = 1'b0;
      check("err_clr", 32'(err_valid), 32'd0);
`endif

      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(0, 9))
            0:       ack_at = -1;
            1:       ack_at = TO - 1;
            2:       ack_at = TO - 2;
            default: ack_at = int'($urandom_range(0, 3));
         endcase
         run_txn(1'($urandom_range(0, 1)),
                 (ack_at < 0) ? 32'h5000_0000 : {26'h100_0000, 4'($urandom_range(0, 15)), 2'b00},
                 $urandom, ack_at);
      end

      // Reset in the middle of an access
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h5000_0000;
      @(negedge clk);
      cpu_req = 1'b0;
      check("pre_rst_strobe", 32'(bus_read), 32'd1);
      rst = 1'b1;
      #1;
      check("rst_mid_strobe", {30'd0, bus_write, bus_read}, 32'd0);
      check("rst_mid_ready", {30'd0, cpu_ready, cpu_done}, 32'd2);
`ifdef MM_ERR_CAPTURE_EN
      valid_m = 1'b0;
`endif
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("post_rst", {29'd0, cpu_ready, cpu_done, bus_read}, 32'd4);
      end

      // Request held high: accepts only from IDLE, one per three cycles
      nstb = 0; ndone = 0; nrdy = 0; nboth = 0;
      bus_ack = 1'b1; bus_rdata = 32'h0; cpu_we = 1'b0; cpu_addr = 32'h4000_000C;
      for (int c = 0; c < 13; c++) begin
         cpu_req = (c < 10);
         if (bus_read || bus_write) nstb++;
         if (bus_read && bus_write) nboth++;
         if (cpu_done) ndone++;
         if (cpu_ready && c < 10) nrdy++;
         @(negedge clk);
      end
      bus_ack = 1'b0; cpu_req = 1'b0;
      check("held_strobes", 32'(nstb), 32'd4);
      check("held_dones", 32'(ndone), 32'd4);
      check("held_readies", 32'(nrdy), 32'd4);
      check("held_overlap", 32'(nboth), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
